// File: rtl/ram_burst_pkg.sv
// Shared types and constants for the RAM burst controller.
package ram_burst_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Burst direction encoding on the mode input.
  localparam logic MODE_WR = 1'b0;
  localparam logic MODE_RD = 1'b1;

  // Read-return buffer depth; the issue throttle is sized against this.
  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/ram_burst_ctrl_if.sv
// Command, stream and RAM-side signals of the burst controller.
// slave = the controller's view, master = the surrounding system (incl. RAM).
interface ram_burst_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  // Command channel
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  // Write stream
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  // Read stream
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_ready;
  // RAM port
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  start, mode, base_addr, len, s_valid, s_data, m_ready, ram_dout,
    output busy, done, s_ready, m_valid, m_data, m_last, ram_we, ram_addr, ram_din
  );

  modport master (
    output start, mode, base_addr, len, s_valid, s_data, m_ready, ram_dout,
    input  busy, done, s_ready, m_valid, m_data, m_last, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/stream_fifo2.sv
// Two-entry FIFO holding read-return words (data plus last flag).
// Push and pop may happen in the same cycle, including when full.
module stream_fifo2
  import ram_burst_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic         pop_ok;
  logic         push_ok;

  // A pop on empty is dropped; a push on full is accepted only with a pop.
  assign pop_ok  = pop_i && (count_q != 2'd0);
  assign push_ok = push_i && ((count_q != 2'(FIFO_DEPTH)) || pop_ok);

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Storage: write the incoming word into the slot at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst controller in front of a synchronous-read RAM: turns a write stream
// into consecutive RAM writes and consecutive RAM reads into a read stream,
// buffering the one-cycle read latency so backpressure never loses data.
module ram_burst_ctrl
  import ram_burst_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  ram_burst_ctrl_if.slave bus
);

  localparam logic [ADDR_W:0]   LEN_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  state_t            state_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [ADDR_W:0]   rem_q;
  logic              busy_q;
  logic              done_q;
  logic              s_ready_q;
  logic              inflight_q;
  logic              inflight_last_q;

  logic [1:0]        fifo_count;
  logic [DATA_W:0]   fifo_head;
  logic              in_write;
  logic              wr_hs;
  logic              pop;
  logic              issue;
  logic [2:0]        occupancy;
  logic [ADDR_W-1:0] ram_addr_c;

  assign in_write = (state_q == ST_WRITE);
  assign wr_hs    = in_write && bus.s_valid;
  assign pop      = (fifo_count != 2'd0) && bus.m_ready;

  // Buffer occupancy after this edge; a read issued now lands next cycle,
  // so it may only go out if that slot is guaranteed free.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == ST_READ) && (rem_q != LEN_ZERO) &&
                     (occupancy < 3'(FIFO_DEPTH));

  // Address is driven while writing or issuing a read, otherwise held.
  assign ram_addr_c   = (in_write || issue) ? cur_addr_q : addr_hold_q;
  assign bus.ram_addr = ram_addr_c;
  assign bus.ram_we   = wr_hs;
  assign bus.ram_din  = in_write ? bus.s_data : DATA_ZERO;

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = (fifo_count != 2'd0);
  assign bus.m_data  = fifo_head[DATA_W-1:0];
  assign bus.m_last  = bus.m_valid && fifo_head[DATA_W];

  stream_fifo2 #(
    .W (DATA_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .din_i   ({inflight_last_q, bus.ram_dout}),
    .pop_i   (pop),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  // Burst FSM with its counters, read-pipeline tracking and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cur_addr_q      <= ADDR_ZERO;
      addr_hold_q     <= ADDR_ZERO;
      rem_q           <= LEN_ZERO;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      s_ready_q       <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      inflight_q      <= issue;
      inflight_last_q <= issue && (rem_q == LEN_ONE);
      addr_hold_q     <= ram_addr_c;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.len == LEN_ZERO) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              cur_addr_q <= bus.base_addr;
              rem_q      <= bus.len;
              busy_q     <= 1'b1;
              if (bus.mode == MODE_RD) begin
                state_q <= ST_READ;
              end else begin
                state_q   <= ST_WRITE;
                s_ready_q <= 1'b1;
              end
            end
          end
        end
        ST_WRITE: begin
          if (wr_hs) begin
            cur_addr_q <= cur_addr_q + ADDR_ONE;
            rem_q      <= rem_q - LEN_ONE;
            if (rem_q == LEN_ONE) begin
              state_q   <= ST_DONE;
              busy_q    <= 1'b0;
              s_ready_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (issue) begin
            cur_addr_q <= cur_addr_q + ADDR_ONE;
            rem_q      <= rem_q - LEN_ONE;
          end
          // The tagged last word leaving the buffer ends the burst.
          if (pop && fifo_head[DATA_W]) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          s_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
